csa_accum_resolve: RTL and testbench
====================================

Name: csa_accum_resolve

Overview:
- Sequential multi-operand accumulator that sits downstream of the team's carry-save adder stages.
- Accepts a stream of unsigned WIDTH-bit operands over a valid/ready handshake and keeps the running total in redundant sum/carry form, so there is no carry propagation per beat.
- At end of frame it converts the redundant pair to binary, CHUNK bits per cycle.
- Presents the binary result, operand count and overflow flag on a valid/ready output.

Parameters:
- WIDTH, 8, input operand width (zero-extended to ACC_W).
- ACC_W, 12, accumulator/result width; must satisfy ACC_W >= WIDTH and ACC_W % CHUNK == 0.
- CHUNK, 4, bits resolved per cycle; NCHUNK = ACC_W/CHUNK.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat; high only in state ACCUM.
- in_data  input  WIDTH  unsigned operand.
- in_last  input  1  qualifies the final beat of a frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  ACC_W  binary sum mod 2^ACC_W.
- out_count  output  8  operands in frame, saturates at 255.
- out_ovf  output  1  true sum >= 2^ACC_W (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State = ACCUM; S, C, result, carry register, chunk index and count = 0.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - in_ready=1, since it is a combinational decode of state ACCUM.
  - Reset mid-RESOLVE or mid-OUTPUT abandons the frame; there is no partial output.
- State ACCUM:
  - Per accepted beat (in_valid && in_ready), with X = zero-extended in_data:
    - S <= S^C^X
    - C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to ACC_W.
  - Bit shifted out of C[ACC_W-1] sets the sticky ovf register.
  - count <= min(count+1, 255).
  - If in_last on the accepted beat, go to RESOLVE with chunk index k=0 and carry reg cr=0.
  - in_valid without in_last just accumulates; no timeout.
- State RESOLVE:
  - in_ready=0; in_valid is ignored.
  - Each cycle: {cr, R[k*CHUNK +: CHUNK]} <= S chunk k + C chunk k + cr, then k <= k+1.
  - On the last chunk, a carry-out sets ovf; go to OUTPUT.
  - Exactly NCHUNK cycles.
- State OUTPUT:
  - out_valid=1; out_data=R, out_count=count, out_ovf=ovf, all held stable while out_ready=0.
  - On out_valid && out_ready: out_valid<=0; S, C, count, ovf cleared; return to ACCUM.
  - in_ready rises the cycle after the handshake, so no beat is accepted on the handshake edge.
- Latency:
  - Accept edge of the last beat = edge 0.
  - out_valid is high after edge NCHUNK+1 (edge 4 at defaults).
  - Minimum frame-to-frame turnaround is NCHUNK+2 cycles.
- Arithmetic: unsigned only, result modulo 2^ACC_W. A single-beat frame is legal; an empty frame is impossible.

Optional Feature:
- Macro CSA_ACCUM_OVF_EN.
- Defined: the ovf register, dropped-carry capture and final carry-out capture are built; out_ovf reports them as specified.
- Undefined: no ovf logic is built; out_ovf is tied to 0. Data, count and timing are unchanged.

Test Plan:
- Single beat 0xA5 with in_last -> out_data=0x0A5, out_count=1, out_ovf=0, out_valid rises exactly 4 cycles after the accept edge.
- Beats 0xFF,0xFF,0xFF (last on the third) -> out_data=0x2FD, out_count=3, out_ovf=0.
- 17 beats of 0xFF -> out_data=0x0EF, out_count=17, out_ovf=1 with CSA_ACCUM_OVF_EN and 0 without it.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles while in_valid=1, in_data=0x01, in_last=1 are driven; then out_ready=1.
  - Required: in_ready=0 and out_data stable through the stall; after the handshake, the next frame (0x01 last) gives out_data=0x001, out_count=1.
- Bubbles: 0x10, idle, 0x20, idle, idle, 0x30 (last) -> out_data=0x060, out_count=3.
- Reset mid-RESOLVE:
  - Stimulus: rst_n=0 for 2 cycles during the second resolve cycle, then release.
  - Required: out_valid=0, out_data=0, out_count=0, in_ready=1; the next frame 0x07 (last) gives 0x007.

Source files
------------

// File: rtl/csa_accum_resolve.sv
// csa_accum_resolve: carry-save multi-operand accumulator with a chunked binary resolve.
// Define CSA_ACCUM_OVF_EN to build overflow tracking; without it, out_ovf is tied to 0.
module csa_accum_resolve #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_count,
  output logic             out_ovf
);
  localparam int NCHUNK = ACC_W / CHUNK;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d, r_q, r_d;
  logic [ACC_W-1:0] x, maj;
  logic [CHUNK:0]   csum;
  logic             cr_q, cr_d;
  logic [KW-1:0]    k_q, k_d;
  logic [7:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             accept, last_chunk, hs;

  assign x          = ACC_W'(in_data);
  assign maj        = (s_q & c_q) | (s_q & x) | (c_q & x);
  // S and C are shifted right during resolve, so the low chunk is always the one being summed.
  assign csum       = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]} + (CHUNK+1)'(cr_q);
  assign in_ready   = state_q == ACCUM;
  assign accept     = in_valid && in_ready;
  assign last_chunk = k_q == KW'(NCHUNK - 1);
  assign hs         = out_valid_q && out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = r_q;
  assign out_count  = count_q;

  // Next-state for accumulate, chunked resolve and output hold.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    r_d         = r_q;
    cr_d        = cr_q;
    k_d         = k_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          s_d     = s_q ^ c_q ^ x;
          c_d     = maj << 1;
          count_d = count_q == 8'hFF ? count_q : count_q + 8'd1;
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            cr_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        r_d  = (r_q >> CHUNK) | (ACC_W'(csum[CHUNK-1:0]) << (ACC_W - CHUNK));
        s_d  = s_q >> CHUNK;
        c_d  = c_q >> CHUNK;
        cr_d = csum[CHUNK];
        k_d  = last_chunk ? '0 : k_q + 1'b1;
        if (last_chunk) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_valid_d = !hs;
        if (hs) begin
          state_d = ACCUM;
          s_d     = '0;
          c_d     = '0;
          count_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, datapath and registered output-valid flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      cr_q        <= 1'b0;
      k_q         <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      r_q         <= r_d;
      cr_q        <= cr_d;
      k_q         <= k_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef CSA_ACCUM_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: carries dropped off the top of C, plus the final resolve carry-out.
  always_comb begin
    ovf_d = (state_q == OUTPUT && hs) ? 1'b0 :
            ovf_q | (accept && maj[ACC_W-1]) | (state_q == RESOLVE && last_chunk && csum[CHUNK]);
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accum_resolve.sv
// tb_csa_accum_resolve: scoreboard bench for the carry-save accumulator.
module tb_csa_accum_resolve;
  localparam int WIDTH = 8;
  localparam int ACC_W = 12;
  localparam int CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_data;
  logic [7:0]       out_count;

  int total = 0;
  int bad = 0;
  int m_sum = 0;
  int m_n = 0;

  typedef struct packed {
    logic [ACC_W-1:0] d;
    logic [7:0]       c;
    logic             o;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  csa_accum_resolve #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
  );

  task automatic push_exp;
    exp_t e;
    e.d = m_sum[ACC_W-1:0];
    e.c = m_n > 255 ? 8'd255 : 8'(m_n);
`ifdef CSA_ACCUM_OVF_EN
    e.o = m_sum >= (1 << ACC_W);
`else
    e.o = 1'b0;
`endif
    sb.push_back(e);
    m_sum = 0;
    m_n = 0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic last);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL beat_accept in_ready=%b required=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    m_sum += int'(d);
    m_n++;
    if (last) push_exp();
  endtask

  task automatic wait_check(output int cyc);
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL out_valid_timeout out_valid=%b required=1", out_valid); end
    e = sb.size() > 0 ? sb.pop_front() : '1;
    total++;
    if (out_data !== e.d) begin bad++; $display("FAIL out_data got=%h required=%h", out_data, e.d); end
    total++;
    if (out_count !== e.c) begin bad++; $display("FAIL out_count got=%0d required=%0d", out_count, e.c); end
    total++;
    if (out_ovf !== e.o) begin bad++; $display("FAIL out_ovf got=%b required=%b", out_ovf, e.o); end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hs_out_valid got=%b required=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL hs_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h required=000", out_data); end
    total++;
    if (out_count !== 8'd0) begin bad++; $display("FAIL rst_out_count got=%0d required=0", out_count); end
    total++;
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got=%b required=0", out_ovf); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int cyc;
    beat(8'hA5, 1'b1);
    wait_check(cyc);
    total++;
    if (cyc != 4) begin bad++; $display("FAIL latency got=%0d required=4", cyc); end
    handshake();
  endtask

  task automatic test_three;
    int cyc;
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b1);
    wait_check(cyc);
    handshake();
  endtask

  task automatic test_overflow;
    int cyc;
    for (int i = 0; i < 17; i++) beat(8'hFF, i == 16);
    wait_check(cyc);
    handshake();
  endtask

  task automatic test_backpressure;
    int cyc;
    beat(8'h33, 1'b1);
    wait_check(cyc);
    in_valid = 1'b1;
    in_data = 8'h01;
    in_last = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b required=0", i, in_ready); end
      total++;
      if (out_data !== 12'h033) begin bad++; $display("FAIL stall_out_data cyc=%0d got=%h required=033", i, out_data); end
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid cyc=%0d got=%b required=1", i, out_valid); end
    end
    handshake();
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    m_sum = 1;
    m_n = 1;
    push_exp();
    wait_check(cyc);
    handshake();
  endtask

  task automatic test_bubbles;
    int cyc;
    beat(8'h10, 1'b0);
    @(negedge clk);
    beat(8'h20, 1'b0);
    repeat (2) @(negedge clk);
    beat(8'h30, 1'b1);
    wait_check(cyc);
    handshake();
  endtask

  task automatic test_reset_resolve;
    int cyc;
    beat(8'h55, 1'b1);
    void'(sb.pop_back());
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b required=0", out_valid); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL mid_rst_out_data got=%h required=000", out_data); end
    total++;
    if (out_count !== 8'd0) begin bad++; $display("FAIL mid_rst_out_count got=%0d required=0", out_count); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b required=1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b required=0", out_valid); end
    beat(8'h07, 1'b1);
    wait_check(cyc);
    handshake();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_reset_resolve();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end
endmodule
